// File: rtl/fetch_unit.sv
// fetch_unit: architectural PC register, single-outstanding instruction fetch, decode-facing FIFO.
// Define FETCH_PERF_CNT_EN to add the perf_stall_cycles / perf_flush_count outputs.
module fetch_unit #(
    parameter int unsigned             ADDRESS_SIZE     = 32,
    parameter int unsigned             INSTRUCTION_SIZE = 4,
    parameter int unsigned             DATA_WIDTH       = 32,
    parameter logic [ADDRESS_SIZE-1:0] RESET_VECTOR     = '0,
    parameter int unsigned             FIFO_DEPTH       = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_SIZE-1:0] redirect_addr,
    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    output logic [ADDRESS_SIZE-1:0] imem_req_addr,
    input  logic                    imem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   imem_resp_data,
    output logic                    fetch_valid,
    input  logic                    fetch_ready,
    output logic [DATA_WIDTH-1:0]   fetch_instr,
    output logic [ADDRESS_SIZE-1:0] fetch_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]             perf_stall_cycles,
    output logic [31:0]             perf_flush_count
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDRESS_SIZE-1:0] PC_INC     = ADDRESS_SIZE'(INSTRUCTION_SIZE);
    localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = ~(PC_INC - ADDRESS_SIZE'(1));

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;

    state_t                  state;
    logic [ADDRESS_SIZE-1:0] pc_reg;
    logic [ADDRESS_SIZE-1:0] inflight_pc;
    logic [ADDRESS_SIZE-1:0] pc_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [CNT_W-1:0]        count;
    logic                    req_fire;
    logic                    push;
    logic                    pop;

    // Issue only with a free slot, so the response of the single outstanding request always fits.
    always_comb begin
        fetch_valid    = (count != '0);
        imem_req_valid = rst_n && (state == S_REQ) && (count < CNT_W'(FIFO_DEPTH)) && !redirect_valid;
        imem_req_addr  = pc_reg;
        req_fire       = imem_req_valid && imem_req_ready;
        push           = (state == S_WAIT) && imem_resp_valid && !redirect_valid;
        pop            = fetch_valid && fetch_ready;
        fetch_instr    = fetch_valid ? data_mem[rd_ptr] : '0;
        fetch_pc       = fetch_valid ? pc_mem[rd_ptr] : pc_reg;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= inflight_pc;
            data_mem[wr_ptr] <= imem_resp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_REQ;
            pc_reg      <= RESET_VECTOR;
            inflight_pc <= RESET_VECTOR;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            // Flush subsumes any same-cycle dequeue; a response landing now retires the outstanding request.
            pc_reg <= redirect_addr & ALIGN_MASK;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            case (state)
                S_WAIT:  state <= imem_resp_valid ? S_REQ : S_DRAIN;
                S_DRAIN: if (imem_resp_valid) state <= S_REQ;
                default: state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        inflight_pc <= pc_reg;
                        pc_reg      <= pc_reg + PC_INC;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                        state  <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_resp_valid) state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (fetch_valid && !fetch_ready && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (redirect_valid && (perf_flush_count != '1))
                perf_flush_count <= perf_flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized checks of fetch_unit against a queue-based reference model.
// Perf-counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RV    = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDRESS_SIZE(32), .INSTRUCTION_SIZE(4), .DATA_WIDTH(32),
        .RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_instr(fetch_instr), .fetch_pc(fetch_pc)
`ifdef FETCH_PERF_CNT_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    // Reference model: instruction queue toward decode, next PC, one outstanding request.
    entry_t      q[$];
    logic [31:0] m_pc;
    bit          m_pend;
    bit          m_stale;
    logic [31:0] m_pend_pc;

    // Memory environment: one request in flight, fixed latency per request.
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_data;
    int          lat = 1;

    logic [31:0] acc_log[$];
    logic [31:0] fet_log[$];
    logic [31:0] fet_data_log[$];
    bit          last_acc;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], 16'h0} ^ (a * 32'h0000_9E37) ^ 32'h5A00_00C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc     = RV;
        m_pend   = 1'b0;
        m_stale  = 1'b0;
        mem_busy = 1'b0;
        mem_cnt  = 0;
        acc_log.delete();
        fet_log.delete();
        fet_data_log.delete();
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        fetch_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_addr   = '0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid",   32'(imem_req_valid), 32'd0);
        check("rst_fetch_valid", 32'(fetch_valid),    32'd0);
        check("rst_req_addr",    imem_req_addr,       RV);
        check("rst_fetch_instr", fetch_instr,         32'd0);
        check("rst_fetch_pc",    fetch_pc,            RV);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive at negedge, check settled outputs, advance model and memory.
    task automatic cycle(input bit rf, input bit rd, input logic [31:0] ra, input bit rm);
        bit          resp;
        bit          exp_rv;
        bit          exp_fv;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        fetch_ready     = rf;
        redirect_valid  = rd;
        redirect_addr   = ra;
        imem_req_ready  = rm;
        resp            = mem_busy && (mem_cnt == 0);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mem_data : $urandom;
        #1;
        exp_rv    = !m_pend && (q.size() < DEPTH) && !rd;
        exp_fv    = (q.size() != 0);
        exp_pc    = exp_fv ? q[0].pc : m_pc;
        exp_instr = exp_fv ? q[0].data : 32'd0;
        check("req_valid",   32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) check("req_addr", imem_req_addr, m_pc);
        check("fetch_valid", 32'(fetch_valid), 32'(exp_fv));
        check("fetch_pc",    fetch_pc,    exp_pc);
        check("fetch_instr", fetch_instr, exp_instr);

        last_acc = imem_req_valid && imem_req_ready;
        if (last_acc) acc_log.push_back(imem_req_addr);
        if (fetch_valid && fetch_ready) begin
            fet_log.push_back(fetch_pc);
            fet_data_log.push_back(fetch_instr);
        end

        if (exp_fv && rf) void'(q.pop_front());
        if (rd) begin
            q.delete();
            m_pc = ra & ~32'h3;
            if (m_pend) begin
                if (resp) m_pend = 1'b0;
                else      m_stale = 1'b1;
            end
        end else begin
            if (m_pend && resp) begin
                if (!m_stale) q.push_back(entry_t'{m_pend_pc, word_at(m_pend_pc)});
                m_pend  = 1'b0;
                m_stale = 1'b0;
            end
            if (exp_rv && rm) begin
                m_pend    = 1'b1;
                m_stale   = 1'b0;
                m_pend_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
        end

        if (resp) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (imem_req_valid && imem_req_ready) begin
            mem_busy = 1'b1;
            mem_cnt  = lat - 1;
            mem_data = word_at(imem_req_addr);
        end
        @(negedge clk);
    endtask

    task automatic run_until_accept(input string tag);
        int unsigned n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 40) begin
            cycle(1'b1, 1'b0, '0, 1'b1);
            n++;
        end
        check(tag, 32'(last_acc), 32'd1);
    endtask

    initial begin
        logic [31:0] stale_pc;
        int          hits;
        int          base;

        // Sequential fetch from the reset vector, latency 1, decode always ready.
        lat = 1;
        do_reset();
        repeat (12) cycle(1'b1, 1'b0, '0, 1'b1);
        check("seq_req0", acc_log[0], 32'h100);
        check("seq_req1", acc_log[1], 32'h104);
        check("seq_req2", acc_log[2], 32'h108);
        check("seq_pc0",  fet_log[0], 32'h100);
        check("seq_pc1",  fet_log[1], 32'h104);
        check("seq_pc2",  fet_log[2], 32'h108);
        check("seq_dat0", fet_data_log[0], word_at(32'h100));
        check("seq_dat2", fet_data_log[2], word_at(32'h108));

        // Decode stalled for 10 cycles: fill to depth, then stop requesting.
        do_reset();
        repeat (10) cycle(1'b0, 1'b0, '0, 1'b1);
        check("stall_req_count", 32'(acc_log.size()), 32'(DEPTH));
        #1 check("stall_req_idle", 32'(imem_req_valid), 32'd0);
        repeat (6) cycle(1'b1, 1'b0, '0, 1'b1);
        check("release_pc0", fet_log[0], 32'h100);
        check("release_pc1", fet_log[1], 32'h104);
        check("release_pc2", fet_log[2], 32'h108);

        // Redirect while waiting on a latency-3 response.
        lat = 3;
        run_until_accept("wait_accept_a");
        stale_pc = acc_log[$];
        cycle(1'b1, 1'b1, 32'h0000_2002, 1'b1);
        check("redir_fetch_pc", fetch_pc, 32'h2000);
        run_until_accept("wait_accept_b");
        check("redir_req_addr", acc_log[$], 32'h2000);
        base = fet_log.size();
        repeat (12) cycle(1'b1, 1'b0, '0, 1'b1);
        hits = 0;
        foreach (fet_log[i]) if (fet_log[i] == stale_pc) hits++;
        check("stale_dropped", 32'(hits), 32'd0);
        check("redir_first_pc", fet_log[base], 32'h2000);

        // Redirect coinciding with the response in WAIT.
        lat = 2;
        run_until_accept("wait_accept_c");
        cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000_3000, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check("same_cyc_req", 32'(last_acc), 32'd1);
        check("same_cyc_addr", acc_log[$], 32'h3000);
        repeat (6) cycle(1'b1, 1'b0, '0, 1'b1);

        // PC wrap at the top of the address space.
        lat = 1;
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        run_until_accept("wrap_accept_a");
        check("wrap_addr0", acc_log[$], 32'hFFFF_FFFC);
        run_until_accept("wrap_accept_b");
        check("wrap_addr1", acc_log[$], 32'h0000_0000);
        repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            lat = int'($urandom_range(1, 3));
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                  $urandom, ($urandom_range(0, 3) != 0));
        end

`ifdef FETCH_PERF_CNT_EN
        // Exactly 5 stalled-head cycles followed by 2 redirect cycles.
        lat = 1;
        do_reset();
        repeat (7) cycle(1'b0, 1'b0, '0, 1'b1);
        repeat (2) cycle(1'b1, 1'b1, 32'h0000_0400, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check("perf_stall", perf_stall_cycles, 32'd5);
        check("perf_flush", perf_flush_count,  32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC next-address block.
- Holds the architectural PC register and issues sequential instruction-memory reads.
- Buffers returned instructions in a small FIFO toward decode.
- Consumes PC_next/PC_clear as a redirect and supplies PC_current back to the next-address logic.

Parameters:
- ADDRESS_SIZE, 32, PC and memory address width in bits
- INSTRUCTION_SIZE, 4, instruction size in bytes; sequential PC increment and alignment granule
- DATA_WIDTH, 32, instruction word width in bits
- RESET_VECTOR, 32'h00000000, PC value loaded on reset
- FIFO_DEPTH, 2, instruction buffer entries (power of two, at least 2)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- redirect_valid  input  1  PC_clear from next-address block
- redirect_addr  input  ADDRESS_SIZE  PC_next target
- imem_req_valid  output  1  read request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  ADDRESS_SIZE  fetch address
- imem_resp_valid  input  1  read data returned (latency 1..N cycles, in order)
- imem_resp_data  input  DATA_WIDTH  instruction word
- fetch_valid  output  1  FIFO head valid
- fetch_ready  input  1  decode consumes head
- fetch_instr  output  DATA_WIDTH  head instruction
- fetch_pc  output  ADDRESS_SIZE  head PC; drives PC_current

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc_reg=RESET_VECTOR, FIFO empty, state=REQ.
  - imem_req_valid=0 while in reset; fetch_valid=0; imem_req_addr=RESET_VECTOR; fetch_instr=0; fetch_pc=RESET_VECTOR.
- At most one outstanding memory request.
- FSM states:
  - REQ:
    - imem_req_valid=1 iff FIFO occupancy < FIFO_DEPTH and redirect_valid=0; imem_req_addr=fetch_pc_reg.
    - On valid&ready: latch request PC into inflight_pc, fetch_pc_reg += INSTRUCTION_SIZE (mod 2^ADDRESS_SIZE), go to WAIT.
  - WAIT:
    - imem_req_valid=0.
    - On imem_resp_valid: push {inflight_pc, imem_resp_data}, go to REQ.
    - A slot is guaranteed free because the REQ-state issue condition reserved one.
  - DRAIN:
    - imem_req_valid=0.
    - On imem_resp_valid: discard data, go to REQ.
- Redirect (redirect_valid=1), highest priority:
  - Flush FIFO (occupancy=0, fetch_valid=0 next cycle).
  - fetch_pc_reg <= redirect_addr with low log2(INSTRUCTION_SIZE) bits forced to 0.
  - State update: WAIT -> DRAIN. REQ stays REQ, since no request is issued in a redirect cycle. DRAIN stays DRAIN.
  - If imem_resp_valid arrives in the same cycle as a redirect while in WAIT, the response is discarded and state goes to REQ.
- Simultaneous dequeue and redirect: the dequeue is honoured (decode took the head); the flush still clears everything else.
- Simultaneous push and pop with FIFO full-minus-one or full: both occur and occupancy is unchanged.
- fetch_pc/fetch_instr come from the FIFO head registers: zero combinational path from imem_resp to fetch_*.
- Minimum latency from request accept to fetch_valid: response cycle + 1.
- imem_resp_valid while in REQ (no outstanding request) is ignored.
- fetch_pc when FIFO empty = fetch_pc_reg.
- Reset mid-WAIT: outstanding response abandoned; memory must not return data for it after reset release. This is a system-level rule.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cycles[31:0] and perf_flush_count[31:0], both reset to 0, saturating at 32'hFFFFFFFF.
  - perf_stall_cycles increments each cycle with fetch_valid=1 and fetch_ready=0.
  - perf_flush_count increments each cycle redirect_valid=1.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset with RESET_VECTOR=0x100, memory latency 1, fetch_ready=1:
  - Required: requests at 0x100, 0x104, 0x108.
  - Required: fetch_pc sequence 0x100, 0x104, 0x108 with the matching data.
- fetch_ready=0 for 10 cycles:
  - Required: exactly FIFO_DEPTH requests issued, then imem_req_valid stays 0.
  - Required: on release, head pc=0x100 and no entries lost.
- Redirect to 0x2002 while in WAIT (latency 3):
  - Required: stale response dropped and never reaches fetch_*.
  - Required: next request address 0x2000; fetch_pc=0x2000.
- Redirect in the same cycle as imem_resp_valid in WAIT:
  - Required: data discarded.
  - Required: next cycle state REQ, request at the redirect target.
- PC wrap: RESET_VECTOR=0xFFFFFFFC, two fetches.
  - Required: addresses 0xFFFFFFFC then 0x00000000.
- FETCH_PERF_CNT_EN defined, 5 stall cycles and 2 redirects:
  - Required: perf_stall_cycles=5, perf_flush_count=2.
